// File: rtl/prime_pkg.sv
// Shared types and default sizing for the prime streamer.
package prime_pkg;

  localparam int RANGE_DEF     = 10000;
  localparam int RANGE_W_DEF   = 14;
  localparam int SCAN_W_DEF    = 8;
  localparam int START_VAL_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/first_one_finder.sv
// Lowest-set-bit encoder; purely combinational.
module first_one_finder
  import prime_pkg::*;
#(
  parameter int W  = SCAN_W_DEF,
  parameter int PW = (clog2(W) < 1) ? 1 : clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [PW-1:0] pos
);

  // Walk high to low so the last hit written is the lowest set bit.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        pos   = PW'(i);
      end
    end
  end

endmodule

// File: rtl/prime_streamer.sv
// Streams set-bit indices of a snapshotted prime bitmap, lowest first, one per 2 cycles max.
// First out_valid 2 cycles after start; out_value/out_valid hold until out_ready handshake.
module prime_streamer
  import prime_pkg::*;
#(
  parameter int RANGE     = RANGE_DEF,
  parameter int RANGE_W   = RANGE_W_DEF,
  parameter int SCAN_W    = SCAN_W_DEF,
  parameter int START_VAL = START_VAL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RANGE-1:0]   bitmap,
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RANGE_W-1:0] out_value,
  output logic [RANGE_W-1:0] prime_cnt,
  output logic               done
);

  localparam int IW = RANGE_W + 1;
  localparam int PW = (clog2(SCAN_W) < 1) ? 1 : clog2(SCAN_W);
  localparam logic [IW-1:0] RANGE_I = IW'(RANGE);

  state_e             state_q, state_d;
  logic [RANGE-1:0]   snap_q, snap_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [RANGE_W-1:0] out_value_q, out_value_d;
  logic [RANGE_W-1:0] cnt_q, cnt_d;

  logic [SCAN_W-1:0]  win;
  logic               found;
  logic [PW-1:0]      pos;
  logic [IW-1:0]      idx_hit;
  logic [IW-1:0]      idx_skip;

  // Zero padding above the snapshot masks window bits at positions >= RANGE.
  assign win = SCAN_W'({{SCAN_W{1'b0}}, snap_q} >> idx_q);

  first_one_finder #(.W(SCAN_W), .PW(PW)) u_ffo (
    .vec   (win),
    .found (found),
    .pos   (pos)
  );

  assign idx_hit  = idx_q + IW'(pos) + IW'(1);
  assign idx_skip = idx_q + IW'(SCAN_W);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          snap_d  = bitmap;
          idx_d   = IW'(START_VAL);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (found) begin
          out_value_d = RANGE_W'(idx_q + IW'(pos));
          out_valid_d = 1'b1;
          idx_d       = idx_hit;
          state_d     = EMIT;
        end else begin
          idx_d   = idx_skip;
          state_d = (idx_skip >= RANGE_I) ? DONE : SCAN;
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + RANGE_W'(1);
          state_d     = (idx_q >= RANGE_I) ? DONE : SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q == SCAN) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign prime_cnt = cnt_q;

endmodule

// File: tb/tb_prime_streamer.sv
// Directed bench for prime_streamer at RANGE=32, SCAN_W=4, START_VAL=2.
module tb_prime_streamer;

  localparam logic [31:0] PRIMES = 32'hA08A_28AC;

  logic        clk;
  logic        rst;
  logic [31:0] bitmap;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_value;
  logic [5:0]  prime_cnt;
  logic        done;

  int checks;
  int errors;
  int got_q[$];
  int exp_q[$];
  int done_n;
  int first_v;
  int wait_n;

  prime_streamer #(
    .RANGE     (32),
    .RANGE_W   (6),
    .SCAN_W    (4),
    .START_VAL (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bitmap    (bitmap),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .prime_cnt (prime_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one pass; n counts edges since the start cycle, so the first SCAN is n=1.
  task automatic run_pass(input logic [31:0] bm, input bit rnd, input int mid_at,
                          output int d_n, output int f_v);
    int  n;
    bit  hold;
    bit  prev_hs;
    logic [5:0] held;
    got_q.delete();
    f_v     = -1;
    hold    = 1'b0;
    prev_hs = 1'b0;
    held    = '0;
    bitmap  = bm;
    start   = 1'b1;
    step();
    start = 1'b0;
    n     = 1;
    chk("cnt_clr", prime_cnt, 0);
    chk("busy_on", busy, 1);
    chk("done_clr", done, 0);
    while (!done && n < 500) begin
      if (hold) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_val", out_value, held);
      end
      if (prev_hs) chk("gap", out_valid, 0);
      if (out_valid && f_v < 0) f_v = n;
      if (n == mid_at) begin
        start  = 1'b1;
        bitmap = ~bm;
      end else begin
        start = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_hs   = out_valid && out_ready;
      hold      = out_valid && !out_ready;
      held      = out_value;
      if (prev_hs) got_q.push_back(int'(out_value));
      step();
      n++;
    end
    start = 1'b0;
    d_n   = n;
    chk("done_set", done, 1);
    chk("done_vld", out_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_val"}, got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bitmap    = '0;
    start     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_val", out_value, 0);
    chk("rst_cnt", prime_cnt, 0);
    chk("rst_done", done, 0);

    // 1: primes below 32, consumer always ready
    exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
    run_pass(PRIMES, 1'b0, -1, done_n, first_v);
    check_seq("t1");
    chk("t1_first", first_v, 2);
    chk("t1_cnt", prime_cnt, 11);

    // 2: random backpressure
    run_pass(PRIMES, 1'b1, -1, done_n, first_v);
    check_seq("t2");
    chk("t2_cnt", prime_cnt, 11);

    // 3: empty bitmap
    exp_q = {};
    run_pass(32'h0, 1'b0, -1, done_n, first_v);
    check_seq("t3");
    chk("t3_len", done_n, 9);
    chk("t3_cnt", prime_cnt, 0);

    // 4: top bit only, then bits below START_VAL only
    exp_q = '{31};
    run_pass(32'h8000_0000, 1'b0, -1, done_n, first_v);
    check_seq("t4a");
    chk("t4a_cnt", prime_cnt, 1);
    exp_q = {};
    run_pass(32'h0000_0003, 1'b0, -1, done_n, first_v);
    check_seq("t4b");
    chk("t4b_cnt", prime_cnt, 0);

    // 5: start and bitmap change mid-pass are ignored; fresh start afterwards
    exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
    run_pass(PRIMES, 1'b0, 5, done_n, first_v);
    check_seq("t5");
    chk("t5_cnt", prime_cnt, 11);
    exp_q = '{31};
    run_pass(32'h8000_0000, 1'b0, -1, done_n, first_v);
    check_seq("t5r");
    chk("t5r_cnt", prime_cnt, 1);

    // 6: reset while holding a value in EMIT
    bitmap    = PRIMES;
    out_ready = 1'b0;
    start     = 1'b1;
    step();
    start  = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 10) begin
      step();
      wait_n++;
    end
    chk("t6_vld", out_valid, 1);
    chk("t6_val", out_value, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_vld0", out_valid, 0);
    chk("t6_val0", out_value, 0);
    chk("t6_cnt0", prime_cnt, 0);
    chk("t6_done0", done, 0);
    exp_q = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
    run_pass(PRIMES, 1'b0, -1, done_n, first_v);
    check_seq("t6p");
    chk("t6p_cnt", prime_cnt, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
